// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states and
// the serializer timing constants the rest of the UART slice is built on.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int unsigned BAUD_COUNT = CLK_FREQ / BAUD_RATE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    START  = 2'd2,
    DRAIN  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority pick: returns the first set request at or above ptr,
// wrapping past NUM_REQ-1 back to 0. Purely combinational.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  int unsigned cand;

  // Scan NUM_REQ candidates starting at ptr; first hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one external UART serializer among NUM_REQ requesters. A requester
// is locked in for its whole message (until a byte flagged last, or until it
// stays silent for LOCK_TIMEOUT cycles), so message bytes never interleave.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LOCK_TIMEOUT = 52080
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_active
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic             grant_active_q, grant_active_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_q, last_d;
  logic             blank_q, blank_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic             accept;
  logic [IDX_W-1:0] next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Route the current owner's valid/last/data lanes.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Owner's successor for the round-robin pointer, wrapping at NUM_REQ-1.
  always_comb begin
    if (grant_id_q == IDX_W'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id_q + IDX_W'(1);
    end
  end

  // A byte is taken only when the serializer is free, so one byte at most is in flight.
  always_comb begin
    accept = (state_q == LOCKED) && sel_valid && !tx_busy;
  end

  // Next-state and pulse outputs for the grant/launch/drain sequence.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    grant_id_d     = grant_id_q;
    grant_active_d = grant_active_q;
    tx_data_d      = tx_data_q;
    last_d         = last_q;
    blank_d        = 1'b0;
    to_cnt_d       = '0;
    req_ready      = '0;
    tx_start       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          state_d        = LOCKED;
        end
      end

      LOCKED: begin
        if (accept) begin
          req_ready[grant_id_q] = 1'b1;
          tx_data_d             = sel_data;
          last_d                = sel_last;
          state_d               = START;
        end else if (!sel_valid) begin
          if (to_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + CNT_W'(1);
          end
        end else begin
          // Owner is presenting a byte but the serializer is still busy:
          // the silence counter neither advances nor restarts.
          to_cnt_d = to_cnt_q;
        end
      end

      START: begin
        tx_start = 1'b1;
        blank_d  = 1'b1;
        state_d  = DRAIN;
      end

      DRAIN: begin
        // tx_busy only rises the cycle after tx_start, so the first DRAIN
        // cycle must not read its low level as "serializer done".
        if (!blank_q && !tx_busy) begin
          if (last_q) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end else begin
            state_d = LOCKED;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any byte in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      grant_id_q     <= '0;
      grant_active_q <= 1'b0;
      tx_data_q      <= 8'h00;
      last_q         <= 1'b0;
      blank_q        <= 1'b0;
      to_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_id_q     <= grant_id_d;
      grant_active_q <= grant_active_d;
      tx_data_q      <= tx_data_d;
      last_q         <= last_d;
      blank_q        <= blank_d;
      to_cnt_q       <= to_cnt_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign grant_id     = grant_id_q;
  assign grant_active = grant_active_q;

endmodule
